// File: rtl/dot_acc_pkg.sv
// Shared types and helpers for the dot-product accumulator.
// Optional bias feature is enabled by defining DOT_ACC_BIAS_EN.
package dot_acc_pkg;

    localparam int EXT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sign- or zero-extend the low w bits of v to EXT_W bits.
    function automatic logic [EXT_W-1:0] ext(
        input logic [EXT_W-1:0] v,
        input int               w,
        input logic             sgn
    );
        logic [EXT_W-1:0] mask;
        logic             msb;
        mask = (w >= EXT_W) ? '1 : ((EXT_W'(1) << w) - EXT_W'(1));
        msb  = |(v & (mask & ~(mask >> 1)));
        return (sgn && msb) ? (v | ~mask) : (v & mask);
    endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Combinational multiply-accumulate: Y = C + ext(A*B).
// Signedness of operands and product follows sg.
module mac_acc_unit
    import dot_acc_pkg::*;
#(
    parameter int La   = 4,
    parameter int Lb   = 4,
    parameter int Lacc = 11
) (
    input  logic [La-1:0]   A,
    input  logic [Lb-1:0]   B,
    input  logic [Lacc-1:0] C,
    input  logic            sg,
    output logic [Lacc-1:0] Y
);

    localparam int P = La + Lb;

    logic [P-1:0]    a_ext;
    logic [P-1:0]    b_ext;
    logic [P-1:0]    prod;
    logic [Lacc-1:0] p_ext;

    assign a_ext = sg ? {{Lb{A[La-1]}}, A} : {{Lb{1'b0}}, A};
    assign b_ext = sg ? {{La{B[Lb-1]}}, B} : {{La{1'b0}}, B};

    // Truncation to P bits is exact: the true product always fits.
    assign prod  = a_ext * b_ext;
    assign p_ext = Lacc'(ext(EXT_W'(prod), P, sg));
    assign Y     = C + p_ext;

endmodule

// File: rtl/dot_acc_seq.sv
// Sequential N-element dot-product accumulator with valid/ready I/O.
// Define DOT_ACC_BIAS_EN to add a bias port that seeds the sum.
module dot_acc_seq
    import dot_acc_pkg::*;
#(
    parameter int La   = 4,
    parameter int Lb   = 4,
    parameter int N    = 4,
    parameter int Lacc = La + Lb + $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [La-1:0]   A,
    input  logic [Lb-1:0]   B,
    input  logic            sg,
`ifdef DOT_ACC_BIAS_EN
    input  logic [La+Lb-1:0] bias,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Lacc-1:0] Y
);

    localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
    localparam bit ONE_ELEM = (N == 1);

    state_t          state;
    logic [Lacc-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            sg_q;

    logic            accept;
    logic            mac_sg;
    logic [Lacc-1:0] init;
    logic [Lacc-1:0] mac_c;
    logic [Lacc-1:0] mac_y;

    assign accept = in_valid && in_ready;
    assign mac_sg = (state == IDLE) ? sg : sg_q;

`ifdef DOT_ACC_BIAS_EN
    assign init = Lacc'(ext(EXT_W'(bias), La + Lb, sg));
`else
    assign init = '0;
`endif

    assign mac_c = (state == IDLE) ? init : acc;
    assign Y     = acc;

    mac_acc_unit #(
        .La   (La),
        .Lb   (Lb),
        .Lacc (Lacc)
    ) u_mac (
        .A  (A),
        .B  (B),
        .C  (mac_c),
        .sg (mac_sg),
        .Y  (mac_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sg_q      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sg_q <= sg;
                        acc  <= mac_y;
                        cnt  <= CW'(1);
                        if (ONE_ELEM) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= mac_y;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_acc_seq.sv
// Directed self-checking bench for dot_acc_seq (La=Lb=4, N=4).
// Bias scenario is built only when DOT_ACC_BIAS_EN is defined.
module tb_dot_acc_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        sg;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] Y;
`ifdef DOT_ACC_BIAS_EN
    logic [7:0]  bias;
`endif

    int passed;
    int failed;
    int total;

    dot_acc_seq #(
        .La (4),
        .Lb (4),
        .N  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sg        (sg),
`ifdef DOT_ACC_BIAS_EN
        .bias      (bias),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back elements, then one DONE cycle drained with out_ready.
    task automatic run_vec(input string tag, input logic sg_first,
                           input logic sg_rest, input logic [3:0] a,
                           input logic [3:0] b, input logic [10:0] exp_y);
        in_valid = 1'b1;
        A = a;
        B = b;
        for (int i = 0; i < 4; i++) begin
            sg = (i == 0) ? sg_first : sg_rest;
            tick();
            chk({tag, "_ov"}, out_valid, (i == 3));
        end
        in_valid = 1'b0;
        chk({tag, "_y"}, Y, exp_y);
        chk({tag, "_rdy_done"}, in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_idle"}, out_valid, 1'b0);
        chk({tag, "_rdy_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        passed    = 0;
        failed    = 0;
        total     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        sg        = 1'b0;
`ifdef DOT_ACC_BIAS_EN
        bias      = '0;
`endif
        tick();
        tick();
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_y", Y, 11'd0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", in_ready, 1'b1);

        run_vec("uns", 1'b0, 1'b0, 4'd15, 4'd15, 11'd900);
        run_vec("s_neg", 1'b1, 1'b1, 4'h8, 4'h8, 11'd256);
        run_vec("s_mix", 1'b1, 1'b1, 4'd7, 4'h8, 11'h720);
        run_vec("sg_latch", 1'b1, 1'b0, 4'hF, 4'd2, 11'h7F8);

        // Backpressure: DONE must hold and refuse new elements.
        in_valid = 1'b1;
        sg = 1'b0;
        A = 4'd15;
        B = 4'd15;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_ov0", out_valid, 1'b1);
        A = 4'd1;
        B = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ov", out_valid, 1'b1);
            chk("bp_y", Y, 11'd900);
            chk("bp_rdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_ov", out_valid, 1'b0);
        chk("bp_rel_rdy", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_next_ov", out_valid, (i == 3));
        end
        in_valid = 1'b0;
        chk("bp_next_y", Y, 11'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a vector discards the partial sum.
        in_valid = 1'b1;
        A = 4'd5;
        B = 4'd3;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", out_valid, 1'b0);
        chk("mid_rst_y", Y, 11'd0);
        chk("mid_rst_rdy", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        run_vec("post_rst", 1'b0, 1'b0, 4'd1, 4'd1, 11'd4);

`ifdef DOT_ACC_BIAS_EN
        bias = 8'hF0;
        run_vec("bias_s", 1'b1, 1'b1, 4'd3, 4'd3, 11'd20);
        run_vec("bias_u", 1'b0, 1'b0, 4'd3, 4'd3, 11'd276);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
